// File: rtl/crypt_pkg.sv
// -----------------------------------------------------------------------------
// crypt_pkg
// Shared types and constants for the frame-level crypt controller.
//   state_t   : controller FSM states
//   CFG_*     : configuration register addresses
//   cfg_t     : key / rotation / mode configuration bundle
//   cfg_apply : applies one config write to a cfg_t
// -----------------------------------------------------------------------------
package crypt_pkg;

    typedef enum logic [1:0] {
        GATHER     = 2'd0,
        WAIT_SPACE = 2'd1,
        BURST      = 2'd2,
        DRAIN      = 2'd3
    } state_t;

    localparam logic [1:0] CFG_K1   = 2'd0;
    localparam logic [1:0] CFG_K2   = 2'd1;
    localparam logic [1:0] CFG_K3   = 2'd2;
    localparam logic [1:0] CFG_CTRL = 2'd3;

    typedef struct packed {
        logic [7:0] k1;
        logic [7:0] k2;
        logic [7:0] k3;
        logic       mode;
        logic [2:0] rot_freq;
    } cfg_t;

    // Mode defaults to crypt (1); keys and rotation default to zero.
    localparam cfg_t CFG_RESET = '{k1: 8'h00, k2: 8'h00, k3: 8'h00,
                                   mode: 1'b1, rot_freq: 3'd0};

    function automatic cfg_t cfg_apply(cfg_t cur, logic [1:0] addr, logic [7:0] wdata);
        cfg_t nxt;
        nxt = cur;
        case (addr)
            CFG_K1:  nxt.k1 = wdata;
            CFG_K2:  nxt.k2 = wdata;
            CFG_K3:  nxt.k3 = wdata;
            default: begin
                nxt.mode     = wdata[3];
                nxt.rot_freq = wdata[2:0];
            end
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/crypt_sync_fifo.sv
// -----------------------------------------------------------------------------
// crypt_sync_fifo
// Synchronous first-word-fall-through FIFO with occupancy count.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   wr_en, wr_data  : push
//   rd_en, rd_data  : pop; rd_data shows the head entry combinationally
//   count           : current occupancy (0..DEPTH)
// A push and a pop in the same cycle are both performed, including when full.
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module crypt_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full, empty, do_wr, do_rd;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Callers size their traffic so this never fires; a hit means a lost byte.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
                                    !(wr_en && full && !do_rd));

endmodule

// File: rtl/crypt_frame_ctrl.sv
// -----------------------------------------------------------------------------
// crypt_frame_ctrl
// Frame-level owner of the shared XOR crypt pipe. Buffers one upstream frame,
// replays it to the pipe as one contiguous enable burst (so key rotation is not
// restarted mid-frame), and collects the pipe output into a framed output FIFO.
// Ports:
//   clk, rst                      : clock, asynchronous active-low reset
//   cfg_we/cfg_addr/cfg_wdata     : staging config writes (k1,k2,k3,ctrl)
//   s_valid/s_ready/s_data/s_last : upstream byte stream
//   pipe_en/pipe_din/pipe_k*/
//   pipe_rot_freq/pipe_mode       : drive to the crypt pipe (active config)
//   pipe_valid/pipe_data          : crypt pipe result (1-cycle latency)
//   m_valid/m_ready/m_data/m_last : downstream byte stream
//   frame_cnt/byte_cnt            : statistics, live only with
//                                   CRYPT_FRAME_CTRL_STATS_EN defined
// -----------------------------------------------------------------------------
module crypt_frame_ctrl
    import crypt_pkg::*;
#(
    parameter int FRAME_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [7:0]  cfg_wdata,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        pipe_en,
    output logic [7:0]  pipe_din,
    output logic [7:0]  pipe_k1,
    output logic [7:0]  pipe_k2,
    output logic [7:0]  pipe_k3,
    output logic [2:0]  pipe_rot_freq,
    output logic        pipe_mode,
    input  logic        pipe_valid,
    input  logic [7:0]  pipe_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic [15:0] frame_cnt,
    output logic [15:0] byte_cnt
);
    localparam int             LW          = $clog2(FRAME_MAX) + 1;
    localparam logic [LW-1:0]  FRAME_MAX_L = LW'(FRAME_MAX);

    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] pop_cnt_q, pop_cnt_d;
    logic [LW-1:0] push_cnt_q, push_cnt_d;
    cfg_t          stage_q, act_q, act_d;
    logic          byp_valid_q;
    logic [7:0]    byp_data_q;

    logic [LW-1:0] in_count, out_count, out_free;
    logic [7:0]    in_head;
    logic [8:0]    out_head;
    logic          s_accept, in_pop, out_push, out_pop, push_last;
    logic [7:0]    push_data;

    // ---------------- FIFOs ----------------
    crypt_sync_fifo #(.WIDTH(8), .DEPTH(FRAME_MAX)) u_in_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (s_accept),
        .wr_data (s_data),
        .rd_en   (in_pop),
        .rd_data (in_head),
        .count   (in_count)
    );

    crypt_sync_fifo #(.WIDTH(9), .DEPTH(FRAME_MAX)) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (out_push),
        .wr_data ({push_last, push_data}),
        .rd_en   (out_pop),
        .rd_data (out_head),
        .count   (out_count)
    );

    assign s_ready  = (state_q == GATHER) && (in_count < FRAME_MAX_L);
    assign s_accept = s_valid && s_ready;
    assign out_free = FRAME_MAX_L - out_count;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= GATHER;
            len_q     <= '0;
            pop_cnt_q <= '0;
            act_q     <= CFG_RESET;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            pop_cnt_q <= pop_cnt_d;
            act_q     <= act_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        pop_cnt_d = pop_cnt_q;
        act_d     = act_q;
        in_pop    = 1'b0;
        pipe_en   = 1'b0;
        pipe_din  = 8'h00;
        case (state_q)
            GATHER: begin
                if (s_accept) begin
                    len_d = len_q + 1'b1;
                    // Close on s_last or when the frame reaches its maximum.
                    if (s_last || (len_q == FRAME_MAX_L - 1'b1)) begin
                        state_d = WAIT_SPACE;
                        // Staging as it stood before this cycle; a write in
                        // this same cycle only reaches staging.
                        act_d   = stage_q;
                    end
                end
            end
            WAIT_SPACE: begin
                // Reserve room for the whole frame so the burst never stalls.
                if (out_free >= len_q) begin
                    state_d   = BURST;
                    pop_cnt_d = '0;
                end
            end
            BURST: begin
                in_pop    = 1'b1;
                pipe_din  = in_head;
                pipe_en   = act_q.mode;
                pop_cnt_d = pop_cnt_q + 1'b1;
                if (pop_cnt_q == len_q - 1'b1) state_d = DRAIN;
            end
            DRAIN: begin
                // len is still needed here: the frame's last push lands now.
                state_d = GATHER;
                len_d   = '0;
            end
            default: state_d = GATHER;
        endcase
    end

    // ---------------- staging config ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        stage_q <= CFG_RESET;
        else if (cfg_we) stage_q <= cfg_apply(stage_q, cfg_addr, cfg_wdata);
    end

    assign pipe_k1       = act_q.k1;
    assign pipe_k2       = act_q.k2;
    assign pipe_k3       = act_q.k3;
    assign pipe_rot_freq = act_q.rot_freq;
    assign pipe_mode     = act_q.mode;

    // ---------------- output capture ----------------
    // Bypass delays the popped byte one cycle to line up with the pipe latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byp_valid_q <= 1'b0;
            byp_data_q  <= 8'h00;
            push_cnt_q  <= '0;
        end else begin
            byp_valid_q <= (state_q == BURST) && !act_q.mode;
            byp_data_q  <= in_head;
            push_cnt_q  <= push_cnt_d;
        end
    end

    always_comb begin
        out_push   = act_q.mode ? pipe_valid : byp_valid_q;
        push_data  = act_q.mode ? pipe_data  : byp_data_q;
        push_last  = (LW'(push_cnt_q + 1'b1) == len_q);
        push_cnt_d = push_cnt_q;
        if (out_push) push_cnt_d = push_last ? '0 : push_cnt_q + 1'b1;
    end

    // Head bits are gated so the outputs read zero when the FIFO is empty.
    assign m_valid = (out_count != '0);
    assign m_data  = m_valid ? out_head[7:0] : 8'h00;
    assign m_last  = m_valid && out_head[8];
    assign out_pop = m_valid && m_ready;

    // ---------------- statistics ----------------
`ifdef CRYPT_FRAME_CTRL_STATS_EN
    logic [15:0] frame_cnt_q, byte_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= 16'h0000;
            byte_cnt_q  <= 16'h0000;
        end else if (out_pop) begin
            byte_cnt_q <= byte_cnt_q + 16'd1;
            if (m_last) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign byte_cnt  = byte_cnt_q;
`else
    assign frame_cnt = 16'h0000;
    assign byte_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_crypt_frame_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_crypt_frame_ctrl
// Self-checking bench for crypt_frame_ctrl with a behavioural crypt pipe and a
// frame-level scoreboard (expected bytes computed per frame from the config
// that was staged when the frame closed).
// -----------------------------------------------------------------------------
module tb_crypt_frame_ctrl;
    localparam int FRAME_MAX = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [7:0]  cfg_wdata = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic        s_last = 1'b0;
    logic        pipe_en;
    logic [7:0]  pipe_din, pipe_k1, pipe_k2, pipe_k3;
    logic [2:0]  pipe_rot_freq;
    logic        pipe_mode;
    logic        pipe_valid;
    logic [7:0]  pipe_data;
    logic        m_valid, m_ready, m_last;
    logic [7:0]  m_data;
    logic [15:0] frame_cnt, byte_cnt;

    logic        man_ready = 1'b1;
    logic        rand_ready = 1'b0;
    logic        rnd_ready = 1'b1;
    assign m_ready = rand_ready ? rnd_ready : man_ready;

    always #5 clk = ~clk;

    crypt_frame_ctrl #(.FRAME_MAX(FRAME_MAX)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .pipe_en(pipe_en), .pipe_din(pipe_din),
        .pipe_k1(pipe_k1), .pipe_k2(pipe_k2), .pipe_k3(pipe_k3),
        .pipe_rot_freq(pipe_rot_freq), .pipe_mode(pipe_mode),
        .pipe_valid(pipe_valid), .pipe_data(pipe_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .frame_cnt(frame_cnt), .byte_cnt(byte_cnt)
    );

    // Behavioural XOR pipe: 1-cycle latency, key k1->k2->k3 rotating after
    // every rot_freq+1 enabled bytes, restarting at k1 on any en-low cycle.
    logic [1:0] p_kidx;
    logic [2:0] p_rcnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_valid <= 1'b0; pipe_data <= 8'h00; p_kidx <= 2'd0; p_rcnt <= 3'd0;
        end else begin
            pipe_valid <= pipe_en;
            pipe_data  <= pipe_din ^ ((p_kidx == 2'd0) ? pipe_k1 :
                                      (p_kidx == 2'd1) ? pipe_k2 : pipe_k3);
            if (pipe_en) begin
                if (p_rcnt == pipe_rot_freq) begin
                    p_rcnt <= 3'd0;
                    p_kidx <= (p_kidx == 2'd2) ? 2'd0 : 2'(p_kidx + 2'd1);
                end else begin
                    p_rcnt <= 3'(p_rcnt + 3'd1);
                end
            end else begin
                p_rcnt <= 3'd0; p_kidx <= 2'd0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        rnd_ready = 1'($urandom);
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] st_k1 = 8'h00, st_k2 = 8'h00, st_k3 = 8'h00;
    logic       st_mode = 1'b1;
    logic [2:0] st_rf = 3'd0;
    logic [8:0] exp_q[$];
    logic [7:0] cur_q[$];

    task automatic close_frame();
        int n;
        n = cur_q.size();
        for (int i = 0; i < n; i++) begin
            int sel;
            logic [7:0] k;
            sel = (i / (int'(st_rf) + 1)) % 3;
            k   = (sel == 0) ? st_k1 : (sel == 1) ? st_k2 : st_k3;
            exp_q.push_back({(i == n - 1), (st_mode ? (cur_q[i] ^ k) : cur_q[i])});
        end
        cur_q.delete();
    endtask

    // ---------------- monitors ----------------
    int          cyc = 0;
    int          en_run = 0, last_run = 0, runs_done = 0, en_rise_cyc = -1;
    int          mv_rise_cyc = -1, last_acc_cyc = 0;
    logic        en_prev = 1'b0, mv_prev = 1'b0;
    logic [15:0] exp_frames = 16'h0, exp_bytes = 16'h0;
    logic [8:0]  mon_e;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            if (pipe_en) begin
                if (!en_prev) en_rise_cyc = cyc;
                en_run++;
            end else if (en_run > 0) begin
                last_run = en_run; runs_done++; en_run = 0;
            end
            en_prev = pipe_en;
            if (m_valid && !mv_prev) mv_rise_cyc = cyc;
            mv_prev = m_valid;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {23'd0, m_last, m_data}, 32'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("out byte 0x%02h last %0d (expected 0x%02h last %0d)",
                             m_data, m_last, mon_e[7:0], mon_e[8]);
                    check("m_data", {24'd0, m_data}, {24'd0, mon_e[7:0]});
                    check("m_last", {31'd0, m_last}, {31'd0, mon_e[8]});
                    if (mon_e[8]) exp_frames = exp_frames + 16'd1;
                    exp_bytes = exp_bytes + 16'd1;
                end
            end
        end else begin
            en_prev = 1'b0; en_run = 0; mv_prev = 1'b0;
            exp_frames = 16'h0; exp_bytes = 16'h0;
        end
    end

    // ---------------- stimulus tasks (start/end at posedge+1) ----------------
    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        case (a)
            2'd0:    st_k1 = d;
            2'd1:    st_k2 = d;
            2'd2:    st_k3 = d;
            default: begin st_mode = d[3]; st_rf = d[2:0]; end
        endcase
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, output int stalls);
        stalls = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        @(negedge clk);
        while (!s_ready && stalls < 400) begin
            stalls++;
            @(negedge clk);
        end
        if (!s_ready) check("s_ready_timeout", {31'd0, s_ready}, 32'd1);
        last_acc_cyc = cyc;
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        cur_q.push_back(d);
        if (l || cur_q.size() == FRAME_MAX) close_frame();
    endtask

    task automatic send_frame(input int n, input bit with_last, input bit zeros, output int stalls);
        int s;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            send_byte(zeros ? 8'h00 : 8'($urandom), with_last && (i == n - 1), s);
            stalls += s;
        end
        $display("frame sent: %0d bytes last=%0d stalls=%0d", n, with_last, stalls);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || m_valid || !s_ready) && t < 600) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_pending", exp_q.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_pipe_en();
        int t;
        t = 0;
        while (!pipe_en && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("burst_start", {31'd0, pipe_en}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"},  {31'd0, s_ready},   32'd1);
        check({tag, "_m_valid"},  {31'd0, m_valid},   32'd0);
        check({tag, "_m_last"},   {31'd0, m_last},    32'd0);
        check({tag, "_m_data"},   {24'd0, m_data},    32'd0);
        check({tag, "_pipe_en"},  {31'd0, pipe_en},   32'd0);
        check({tag, "_pipe_din"}, {24'd0, pipe_din},  32'd0);
        check({tag, "_k1"},       {24'd0, pipe_k1},   32'd0);
        check({tag, "_k2"},       {24'd0, pipe_k2},   32'd0);
        check({tag, "_k3"},       {24'd0, pipe_k3},   32'd0);
        check({tag, "_rot"},      {29'd0, pipe_rot_freq}, 32'd0);
        check({tag, "_mode"},     {31'd0, pipe_mode}, 32'd1);
        check({tag, "_frame_cnt"}, {16'd0, frame_cnt}, 32'd0);
        check({tag, "_byte_cnt"},  {16'd0, byte_cnt},  32'd0);
    endtask

    task automatic check_stats();
`ifdef CRYPT_FRAME_CTRL_STATS_EN
        check("frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_frames});
        check("byte_cnt",  {16'd0, byte_cnt},  {16'd0, exp_bytes});
`else
        check("frame_cnt", {16'd0, frame_cnt}, 32'd0);
        check("byte_cnt",  {16'd0, byte_cnt},  32'd0);
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int stalls, r0, rel;

        // Reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        check_reset_outputs("rst");
        repeat (10) @(posedge clk);
        #1;
        check("idle_no_en", runs_done + en_run, 32'd0);

        // Bypass frame
        cfg_write(2'd3, 8'h00);
        r0 = runs_done;
        send_byte(8'h11, 1'b0, stalls);
        send_byte(8'h22, 1'b0, stalls);
        send_byte(8'h33, 1'b1, stalls);
        wait_drain();
        check("bypass_no_en", runs_done - r0, 32'd0);
        check("bypass_latency", mv_rise_cyc, last_acc_cyc + 4);

        // Crypt frame
        cfg_write(2'd0, 8'h5A);
        cfg_write(2'd1, 8'hA5);
        cfg_write(2'd2, 8'h3C);
        cfg_write(2'd3, 8'h09);
        r0 = runs_done;
        send_frame(8, 1'b1, 1'b1, stalls);
        wait_drain();
        check("crypt_runs", runs_done - r0, 32'd1);
        check("crypt_run_len", last_run, 32'd8);
        check("crypt_en_rise", en_rise_cyc, last_acc_cyc + 2);
        check("crypt_latency", mv_rise_cyc, last_acc_cyc + 4);

        // Truncation: 20 bytes, no s_last
        r0 = runs_done;
        send_frame(20, 1'b0, 1'b0, stalls);
        check("trunc_stall_cycles", stalls, 32'd18);
        check("trunc_run_len", last_run, 32'd16);
        check("trunc_leftover_ready", {31'd0, s_ready}, 32'd1);
        send_byte(8'($urandom), 1'b1, stalls);
        wait_drain();
        check("trunc_runs", runs_done - r0, 32'd2);
        check("trunc_tail_len", last_run, 32'd5);

        // Backpressure: two 10-byte frames with m_ready low
        man_ready = 1'b0;
        r0 = runs_done;
        send_frame(10, 1'b1, 1'b0, stalls);
        send_frame(10, 1'b1, 1'b0, stalls);
        repeat (20) @(posedge clk);
        #1;
        check("bp_held_runs", runs_done - r0 + en_run, 32'd1);
        check("bp_held_sready", {31'd0, s_ready}, 32'd0);
        check("bp_held_mvalid", {31'd0, m_valid}, 32'd1);
        rel = cyc;
        man_ready = 1'b1;
        wait_drain();
        check("bp_burst_start", en_rise_cyc, rel + 5);
        check("bp_runs", runs_done - r0, 32'd2);
        check("bp_run_len", last_run, 32'd10);

        // Key write during BURST
        send_frame(12, 1'b1, 1'b0, stalls);
        wait_pipe_en();
        cfg_write(2'd0, 8'hFF);
        check("midburst_k1_old", {24'd0, pipe_k1}, 32'h5A);
        check("midburst_still_en", {31'd0, pipe_en}, 32'd1);
        wait_drain();
        send_frame(4, 1'b1, 1'b0, stalls);
        check("next_frame_k1", {24'd0, pipe_k1}, 32'hFF);
        wait_drain();

        // Reset during BURST
        send_frame(12, 1'b1, 1'b0, stalls);
        wait_pipe_en();
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        cur_q.delete();
        st_k1 = 8'h00; st_k2 = 8'h00; st_k3 = 8'h00; st_mode = 1'b1; st_rf = 3'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        r0 = runs_done;
        send_frame(5, 1'b1, 1'b0, stalls);
        wait_drain();
        check("post_rst_runs", runs_done - r0, 32'd1);
        check("post_rst_run_len", last_run, 32'd5);
        check_stats();

        // Randomized frames with random downstream readiness
        rand_ready = 1'b1;
        for (int f = 0; f < 8; f++) begin
            cfg_write(2'd0, 8'($urandom));
            cfg_write(2'd1, 8'($urandom));
            cfg_write(2'd2, 8'($urandom));
            cfg_write(2'd3, {4'd0, 1'($urandom), 3'($urandom)});
            send_frame($urandom_range(1, FRAME_MAX), 1'b1, 1'b0, stalls);
        end
        rand_ready = 1'b0;
        man_ready  = 1'b1;
        wait_drain();
        check_stats();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
